rr_mux_n: RTL and testbench



---
 rtl/rr_mux_n.sv | 141 ++++++++++++++
 tb/tb_rr_mux_n.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel, W-bit round-robin multiplexer with valid/ready
// handshakes on every input and a registered output slot.
// Optional burst lock (in_last port plus lock FSM) is built only when the
// macro RR_MUX_LAST_EN is defined; otherwise every beat re-arbitrates.
//
// Lock FSM (RR_MUX_LAST_EN only):
//   state    | meaning
//   UNLOCKED | normal round-robin arbitration
//   LOCKED   | burst in progress; only lock_ch may be granted
module rr_mux_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
`ifdef RR_MUX_LAST_EN
  input  logic [N-1:0]   in_last,
`endif
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic          load;
  logic [SW-1:0] scan_grant;
  logic          scan_vld;
  logic [SW-1:0] grant;
  logic          grant_vld;
  logic          xfer;
  logic [W-1:0]  grant_data;

  // The output slot may take a new beat when empty or being drained this cycle.
  assign load = !out_valid || out_ready;
  assign xfer = load && grant_vld;

  // Rotating priority scan starting just after the last granted channel.
  // Index is wrapped by subtraction so non-power-of-two N never yields >= N.
  always_comb begin
    scan_grant = '0;
    scan_vld   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!scan_vld && in_valid[idx]) begin
        scan_vld   = 1'b1;
        scan_grant = SW'(idx);
      end
    end
  end

`ifdef RR_MUX_LAST_EN
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  lock_e         lock_q, lock_d;
  logic [SW-1:0] lock_ch, lock_ch_d;

  // While locked the burst owner is the only candidate, even if it is idle.
  always_comb begin
    grant     = scan_grant;
    grant_vld = scan_vld;
    if (lock_q == LOCKED) begin
      grant     = lock_ch;
      grant_vld = in_valid[lock_ch];
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= UNLOCKED;
      lock_ch <= '0;
    end else begin
      lock_q  <= lock_d;
      lock_ch <= lock_ch_d;
    end
  end

  // Lock next-state: a non-last beat opens a burst, a last beat closes it.
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch;
    case (lock_q)
      UNLOCKED: begin
        if (xfer && !in_last[grant]) begin
          lock_d    = LOCKED;
          lock_ch_d = grant;
        end
      end
      LOCKED: begin
        if (xfer && in_last[grant]) lock_d = UNLOCKED;
      end
      default: lock_d = UNLOCKED;
    endcase
  end
`else
  // Without burst support the scan result is the grant.
  always_comb begin
    grant     = scan_grant;
    grant_vld = scan_vld;
  end
`endif

  // Ready only for the granted channel, and only when the slot can load.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(grant) == i) grant_data = in_data[i*W +: W];
    end
  end

  // Output slot and pointer; data/sel hold when the slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(N - 1);
    end else if (load) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_data <= grant_data;
        out_sel  <= grant;
        ptr      <= grant;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: instance a (N=4, W=8) and instance b (N=3, W=4),
// a per-cycle reference model, plus directed literal expectations.
// Burst-lock stimulus is included when RR_MUX_LAST_EN is defined.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_valid, a_out_ready;

  logic [11:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [3:0]  b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_valid, b_out_ready;
`ifdef RR_MUX_LAST_EN
  logic [3:0]  a_in_last;
  logic [2:0]  b_in_last;
`endif

  int checks = 0;
  int errors = 0;

  rr_mux_n #(.N(4), .W(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
`ifdef RR_MUX_LAST_EN
    .in_last(a_in_last),
`endif
    .out_data(a_out_data), .out_sel(a_out_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  rr_mux_n #(.N(3), .W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
`ifdef RR_MUX_LAST_EN
    .in_last(b_in_last),
`endif
    .out_data(b_out_data), .out_sel(b_out_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ptr[2]  = '{3, 2};
  bit m_vld[2]  = '{0, 0};
  int m_data[2] = '{0, 0};
  int m_sel[2]  = '{0, 0};
  bit m_lock[2] = '{0, 0};
  int m_lch[2]  = '{0, 0};

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function logic [15:0] vin(input int i);
    return (i == 0) ? {12'd0, a_in_valid} : {13'd0, b_in_valid};
  endfunction

  function int din(input int i, input int g);
    return (i == 0) ? int'(a_in_data[g*8 +: 8]) : int'(b_in_data[g*4 +: 4]);
  endfunction

  function bit ordy(input int i);
    return (i == 0) ? a_out_ready : b_out_ready;
  endfunction

`ifdef RR_MUX_LAST_EN
  function logic [15:0] lin(input int i);
    return (i == 0) ? {12'd0, a_in_last} : {13'd0, b_in_last};
  endfunction
`endif

  // Candidate order is ptr+1, ptr+2, ... mod n; first valid one wins.
  function automatic int arb(input int n, input int ptr, input logic [15:0] v,
                             input bit locked, input int lch);
    int order[$];
    if (locked) return v[lch] ? lch : -1;
    for (int k = 1; k <= n; k++) order.push_back((ptr + k) % n);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ptr[i] = nch(i) - 1; m_vld[i] = 0; m_data[i] = 0;
        m_sel[i] = 0; m_lock[i] = 0; m_lch[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ld;
        int g;
        ld = !m_vld[i] || ordy(i);
        g = arb(nch(i), m_ptr[i], vin(i), m_lock[i], m_lch[i]);
        if (ld) begin
          if (g >= 0) begin
`ifdef RR_MUX_LAST_EN
            logic [15:0] l;
            l = lin(i);
            if (!m_lock[i] && !l[g]) begin m_lock[i] = 1; m_lch[i] = g; end
            else if (m_lock[i] && l[g]) m_lock[i] = 0;
`endif
            m_data[i] = din(i, g);
            m_sel[i]  = g;
            m_vld[i]  = 1;
            m_ptr[i]  = g;
          end else begin
            m_vld[i] = 0;
          end
        end
      end
    end
  end

  function automatic int exp_ready(input int i);
    bit ld;
    int g;
    ld = !m_vld[i] || ordy(i);
    g = arb(nch(i), m_ptr[i], vin(i), m_lock[i], m_lch[i]);
    return (ld && g >= 0) ? (1 << g) : 0;
  endfunction

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    chk("a_valid", 32'(a_out_valid), 32'(m_vld[0]));
    chk("a_data",  32'(a_out_data),  m_data[0]);
    chk("a_sel",   32'(a_out_sel),   m_sel[0]);
    chk("a_ready", 32'(a_in_ready),  exp_ready(0));
    chk("b_valid", 32'(b_out_valid), 32'(m_vld[1]));
    chk("b_data",  32'(b_out_data),  m_data[1]);
    chk("b_sel",   32'(b_out_sel),   m_sel[1]);
    chk("b_ready", 32'(b_in_ready),  exp_ready(1));
    chk("b_sel_range", 32'(b_out_sel < 2'd3), 32'd1);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b1;
`ifdef RR_MUX_LAST_EN
    a_in_last = '0; b_in_last = '0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset state with no requests
    step();
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_sel",   32'(a_out_sel),   0);
    chk("rst_a_ready", 32'(a_in_ready),  0);
    chk("rst_b_ready", 32'(b_in_ready),  0);

    // fairness: all channels valid, grants 0,1,2,3,0,1
    a_in_data  = 32'h13121110;
    a_in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fair_sel",   32'(a_out_sel),   k % 4);
      chk("fair_data",  32'(a_out_data),  32'h10 + (k % 4));
      chk("fair_valid", 32'(a_out_valid), 1);
    end

    // single channel 2 with 0xA5, one cycle latency
    a_in_data  = 32'h00A50000;
    a_in_valid = 4'b0100;
    step();
    chk("single_data",  32'(a_out_data),  32'hA5);
    chk("single_sel",   32'(a_out_sel),   2);
    chk("single_valid", 32'(a_out_valid), 1);
    a_in_valid = 4'b0000;
    step();
    chk("idle_valid", 32'(a_out_valid), 0);
    chk("idle_data",  32'(a_out_data),  32'hA5);
    chk("idle_sel",   32'(a_out_sel),   2);

    // backpressure holding 0x3C from channel 0
    a_in_data  = 32'h2322213C;
    a_in_valid = 4'b0001;
    step();
    chk("bp_load_data", 32'(a_out_data), 32'h3C);
    a_out_ready = 1'b0;
    a_in_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data",  32'(a_out_data),  32'h3C);
      chk("bp_hold_valid", 32'(a_out_valid), 1);
      chk("bp_ready",      32'(a_in_ready),  0);
    end
    a_out_ready = 1'b1;
    step();
    chk("bp_next_sel",  32'(a_out_sel),  1);
    chk("bp_next_data", 32'(a_out_data), 32'h21);

    // asynchronous reset between edges while out_valid=1
    a_in_valid  = 4'b0000;
    a_out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_out_valid), 0);
    chk("async_rst_data",  32'(a_out_data),  0);
    chk("async_rst_sel",   32'(a_out_sel),   0);
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b1;

    // N=3 wrap: channels 0 and 2 from ptr=2, grants 0,2,0,2
    b_in_data  = 12'hC0A;
    b_in_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("wrap_sel",  32'(b_out_sel),  (k % 2) * 2);
      chk("wrap_data", 32'(b_out_data), (k % 2) ? 32'hC : 32'hA);
    end
    b_in_valid = 3'b000;

`ifdef RR_MUX_LAST_EN
    // single-beat burst on ch0 moves ptr to 0 and stays unlocked
    a_in_data  = 32'h00007170;
    a_in_valid = 4'b0001;
    a_in_last  = 4'b0001;
    step();
    chk("lock_pre_sel", 32'(a_out_sel), 0);
    // ch1 burst of three beats while ch0 is valid
    a_in_valid = 4'b0011;
    a_in_last  = 4'b0000;
    step();
    chk("lock_b1_sel", 32'(a_out_sel), 1);
    step();
    chk("lock_b2_sel", 32'(a_out_sel), 1);
    a_in_valid = 4'b0001;
    step();
    chk("lock_gap_valid", 32'(a_out_valid), 0);
    chk("lock_gap_ready", 32'(a_in_ready),  0);
    step();
    chk("lock_gap2_valid", 32'(a_out_valid), 0);
    a_in_valid = 4'b0011;
    a_in_last  = 4'b0010;
    step();
    chk("lock_b3_sel",   32'(a_out_sel),   1);
    chk("lock_b3_valid", 32'(a_out_valid), 1);
    a_in_valid = 4'b0001;
    a_in_last  = 4'b0001;
    step();
    chk("lock_after_sel",  32'(a_out_sel),  0);
    chk("lock_after_data", 32'(a_out_data), 32'h70);
    a_in_valid = 4'b0000;
    a_in_last  = 4'b0000;
`endif

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
